// File: rtl/lcm_seq_if.sv
// lcm_seq_if
//   Request/result bundle for the lcm_seq unit.
//   master: drives start and the operand triple a/b/g, observes status and result.
//   slave : the lcm_seq core.
//   Signals:
//     start      request strobe (only looked at while the core is idle)
//     a, b       unsigned operands, W bits
//     g          gcd(a, b) from the upstream gcd block, W bits
//     busy       core is dividing or multiplying
//     done       one-cycle completion pulse
//     lcm        2W-bit result, held between runs
//     err        inconsistent divisor flag, held like lcm
interface lcm_seq_if #(
    parameter int W = 8
);
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   g;
    logic           busy;
    logic           done;
    logic [2*W-1:0] lcm;
    logic           err;

    modport master (
        output start, a, b, g,
        input  busy, done, lcm, err
    );

    modport slave (
        input  start, a, b, g,
        output busy, done, lcm, err
    );
endinterface

// File: rtl/lcm_seq.sv
// lcm_seq
//   Sequential least-common-multiple unit: lcm = (a / g) * b.
//   A W-step restoring divider produces q = a / g and checks that g divides a
//   exactly; a W-step shift-add multiplier then forms q * b in a 2W-bit
//   accumulator.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous, active-high reset
//     bus  lcm_seq_if slave modport (start, a, b, g in; busy, done, lcm, err out)
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for start; operands are latched on the accept edge
//   DIV   | restoring division of latched a by latched g, one bit per cycle
//   MUL   | shift-add multiply of quotient by latched b, LSB of q first
//   DONE  | one-cycle done pulse; lcm/err valid, then back to IDLE
module lcm_seq #(
    parameter int W = 8
) (
    input  logic      clk,
    input  logic      rst,
    lcm_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int            CW       = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

    state_t         state;
    state_t         state_nxt;

    // a_sh is the dividend shift register; quotient bits enter at its LSB,
    // so after W division steps it holds q and is reused as the multiplier.
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_r;
    logic [W-1:0]   g_r;
    logic [W-1:0]   rem;
    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] lcm_r;
    logic           err_r;
    logic [CW-1:0]  cnt;

    logic [W-1:0]   rem_sh;
    logic [W-1:0]   rem_nxt;
    logic [W-1:0]   a_sh_nxt;
    logic           q_bit;
    logic [2*W-1:0] acc_nxt;
    logic           cnt_tc;
    logic           zero_op;
    logic           g_zero;

    // The bit shifted out of rem is always 0: rem never exceeds the
    // already-consumed prefix of a, which fits in W bits.
    always_comb begin
        rem_sh   = {rem[W-2:0], a_sh[W-1]};
        q_bit    = (rem_sh >= g_r);
        rem_nxt  = q_bit ? (rem_sh - g_r) : rem_sh;
        a_sh_nxt = {a_sh[W-2:0], q_bit};
        acc_nxt  = a_sh[0] ? (acc + mcand) : acc;
    end

    assign cnt_tc  = (cnt == '0);
    assign zero_op = (bus.a == '0) || (bus.b == '0);
    assign g_zero  = (bus.g == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (zero_op || g_zero) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = DIV;
                    end
                end
            end
            DIV: begin
                if (cnt_tc) begin
                    state_nxt = (rem_nxt != '0) ? DONE : MUL;
                end
            end
            MUL: begin
                if (cnt_tc) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_r   <= '0;
            g_r   <= '0;
            rem   <= '0;
            mcand <= '0;
            acc   <= '0;
            lcm_r <= '0;
            err_r <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_r   <= bus.b;
                        g_r   <= bus.g;
                        rem   <= '0;
                        cnt   <= CNT_LOAD;
                        lcm_r <= '0;
                        // Zero operand takes precedence over a zero divisor.
                        err_r <= !zero_op && g_zero;
                    end
                end
                DIV: begin
                    rem  <= rem_nxt;
                    a_sh <= a_sh_nxt;
                    cnt  <= cnt - CW'(1);
                    if (cnt_tc) begin
                        if (rem_nxt != '0) begin
                            err_r <= 1'b1;
                        end else begin
                            cnt   <= CNT_LOAD;
                            acc   <= '0;
                            mcand <= {{W{1'b0}}, b_r};
                        end
                    end
                end
                MUL: begin
                    acc   <= acc_nxt;
                    mcand <= mcand << 1;
                    a_sh  <= a_sh >> 1;
                    cnt   <= cnt - CW'(1);
                    if (cnt_tc) begin
                        lcm_r <= acc_nxt;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = (state == DIV) || (state == MUL);
    assign bus.done = (state == DONE);
    assign bus.lcm  = lcm_r;
    assign bus.err  = err_r;

endmodule

// File: tb/tb_lcm_seq.sv
module tb_lcm_seq;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lcm_seq_if #(.W(W)) bus ();

    lcm_seq #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  g;
        bit          chg;
        logic [15:0] exp_lcm;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One request from IDLE; latency is counted in edges from the accept
    // edge to the edge after which done is seen high.
    task automatic run(input vec_t v, input string tag);
        int lat;
        int busy_n;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = v.a;
        bus.b     = v.b;
        bus.g     = v.g;
        @(negedge clk);
        bus.start = 1'b0;
        if (v.chg) begin
            bus.a = 8'd9;
            bus.b = 8'd9;
            bus.g = 8'd9;
        end
        lat    = 0;
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) busy_n++;
            @(negedge clk);
            lat++;
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, " busy_cycles"}, 32'(busy_n), 32'(v.exp_lat));
        chk({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
        chk({tag, " lcm"}, 32'(bus.lcm), 32'(v.exp_lcm));
        chk({tag, " err"}, 32'(bus.err), 32'(v.exp_err));
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
        chk({tag, " lcm_hold"}, 32'(bus.lcm), 32'(v.exp_lcm));
        chk({tag, " err_hold"}, 32'(bus.err), 32'(v.exp_err));
    endtask

    initial begin
        int  n;
        bit  seen;
        int  done_cnt;
        vec_t v1;

        vecs[0]  = '{a: 8'd12,  b: 8'd8,   g: 8'd4,   chg: 1'b0, exp_lcm: 16'd24,    exp_err: 1'b0, exp_lat: 16};
        vecs[1]  = '{a: 8'd0,   b: 8'd7,   g: 8'd7,   chg: 1'b0, exp_lcm: 16'd0,     exp_err: 1'b0, exp_lat: 0};
        vecs[2]  = '{a: 8'd12,  b: 8'd8,   g: 8'd5,   chg: 1'b0, exp_lcm: 16'd0,     exp_err: 1'b1, exp_lat: 8};
        vecs[3]  = '{a: 8'd12,  b: 8'd8,   g: 8'd0,   chg: 1'b0, exp_lcm: 16'd0,     exp_err: 1'b1, exp_lat: 0};
        vecs[4]  = '{a: 8'd6,   b: 8'd4,   g: 8'd2,   chg: 1'b1, exp_lcm: 16'd12,    exp_err: 1'b0, exp_lat: 16};
        vecs[5]  = '{a: 8'd5,   b: 8'd0,   g: 8'd0,   chg: 1'b0, exp_lcm: 16'd0,     exp_err: 1'b0, exp_lat: 0};
        vecs[6]  = '{a: 8'd3,   b: 8'd9,   g: 8'd5,   chg: 1'b0, exp_lcm: 16'd0,     exp_err: 1'b1, exp_lat: 8};
        vecs[7]  = '{a: 8'd255, b: 8'd255, g: 8'd255, chg: 1'b0, exp_lcm: 16'd255,   exp_err: 1'b0, exp_lat: 16};
        vecs[8]  = '{a: 8'd255, b: 8'd254, g: 8'd1,   chg: 1'b0, exp_lcm: 16'd64770, exp_err: 1'b0, exp_lat: 16};
        vecs[9]  = '{a: 8'd200, b: 8'd150, g: 8'd50,  chg: 1'b0, exp_lcm: 16'd600,   exp_err: 1'b0, exp_lat: 16};
        vecs[10] = '{a: 8'd128, b: 8'd3,   g: 8'd1,   chg: 1'b0, exp_lcm: 16'd384,   exp_err: 1'b0, exp_lat: 16};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.g     = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset lcm", 32'(bus.lcm), 32'd0);
        chk("reset err", 32'(bus.err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back: start held high through the whole first run.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd10;
        bus.b     = 8'd15;
        bus.g     = 8'd5;
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            n++;
        end
        chk("b2b first done_seen", 32'(seen), 32'd1);
        chk("b2b first latency", 32'(n), 32'd16);
        chk("b2b first lcm", 32'(bus.lcm), 32'd30);
        chk("b2b first err", 32'(bus.err), 32'd0);
        bus.a = 8'd255;
        bus.b = 8'd254;
        bus.g = 8'd1;
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        bus.start = 1'b0;
        chk("b2b second done_seen", 32'(seen), 32'd1);
        chk("b2b issue interval", 32'(n), 32'd18);
        chk("b2b second lcm", 32'(bus.lcm), 32'd64770);
        @(negedge clk);

        // Reset while idle with a nonzero held result.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("idle rst lcm", 32'(bus.lcm), 32'd0);

        // Reset on the 5th MUL cycle of 12/8/4.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd12;
        bus.b     = 8'd8;
        bus.g     = 8'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        chk("pre rst busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid rst busy", 32'(bus.busy), 32'd0);
        chk("mid rst done", 32'(bus.done), 32'd0);
        chk("mid rst lcm", 32'(bus.lcm), 32'd0);
        chk("mid rst err", 32'(bus.err), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
            @(negedge clk);
        end
        chk("mid rst stays idle", 32'(done_cnt), 32'd0);
        v1 = '{a: 8'd1, b: 8'd1, g: 8'd1, chg: 1'b0, exp_lcm: 16'd1, exp_err: 1'b0, exp_lat: 16};
        run(v1, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
